// File: rtl/nn_float_pkg.sv
// Shared float32 helpers for the NN output stage: FSM state type, bit-pattern
// constants, NaN test and the monotonic ordering key used by comparators.
package nn_float_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } argmax_state_t;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] FP_EXP_MASK = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

    function automatic logic fp_is_nan(input logic [31:0] x);
        return ((x & FP_EXP_MASK) == FP_EXP_MASK) && (x[22:0] != 23'd0);
    endfunction

    // Unsigned order of the key matches numeric order; -0 folds onto +0.
    function automatic logic [31:0] fp_key(input logic [31:0] x);
        logic [31:0] v;
        v = (x == FP_NEG_ZERO) ? FP_POS_ZERO : x;
        return v[31] ? ~v : (v ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/float_argmax_seq_if.sv
// Start/done handshake bundle for float_argmax_seq: packed input vector,
// start request, and the busy/done/index/max_val result side.
interface float_argmax_seq_if #(
    parameter int SIZE  = 15,
    parameter int IDX_W = 4
);
    logic [32*SIZE-1:0] in;
    logic               start;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   index;
    logic [31:0]        max_val;

    modport master (output in, start, input busy, done, index, max_val);
    modport slave  (input in, start, output busy, done, index, max_val);
endinterface

// File: rtl/float_gt.sv
// Combinational float32 a > b: NaN never wins, a NaN b loses to any number,
// -0 equals +0, infinities order normally.
module float_gt
    import nn_float_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    always_comb begin
        gt = 1'b0;
        if (fp_is_nan(a)) begin
            gt = 1'b0;
        end else if (fp_is_nan(b)) begin
            gt = 1'b1;
        end else begin
            gt = fp_key(a) > fp_key(b);
        end
    end

endmodule

// File: rtl/float_argmax_seq.sv
// Sequential float32 argmax, one element per clock behind start/done.
// Define ARGMAX_INPUT_REG_EN to snapshot `in` on the accepting edge.
module float_argmax_seq
    import nn_float_pkg::*;
#(
    parameter int SIZE  = 15,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    float_argmax_seq_if.slave    bus
);

    localparam int CNT_W = $clog2(SIZE) + 1;

    argmax_state_t      state, next;
    logic [CNT_W-1:0]   counter;
    logic [31:0]        cand, cand_nxt;
    logic [IDX_W-1:0]   cand_idx, idx_nxt;
    logic [31:0]        elem;
    logic               elem_gt;
    logic               accept, step, last, load_out;
    logic [32*SIZE-1:0] src;

`ifdef ARGMAX_INPUT_REG_EN
    logic [32*SIZE-1:0] snap;

    always_ff @(posedge clk) begin
        if (accept) begin
            snap <= bus.in;
        end
    end

    assign src = snap;
`else
    assign src = bus.in;
`endif

    always_comb begin
        elem = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (CNT_W'(i) == counter) begin
                elem = src[32*i +: 32];
            end
        end
    end

    float_gt u_gt (
        .a  (elem),
        .b  (cand),
        .gt (elem_gt)
    );

    assign last = (counter == CNT_W'(SIZE - 1));

    always_comb begin
        next     = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: accept = bus.start;
            ST_SCAN: begin
                bus.busy = 1'b1;
                step     = 1'b1;
                next     = last ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                accept   = bus.start;
                next     = ST_IDLE;
            end
            default: next = ST_IDLE;
        endcase
        if (accept) begin
            next = (SIZE > 1) ? ST_SCAN : ST_DONE;
        end
    end

    // The final comparison and the result load share one edge, so the
    // result registers take the next-candidate values directly.
    always_comb begin
        cand_nxt = cand;
        idx_nxt  = cand_idx;
        if (accept) begin
            cand_nxt = bus.in[31:0];
            idx_nxt  = '0;
        end else if (step && elem_gt) begin
            cand_nxt = elem;
            idx_nxt  = IDX_W'(counter);
        end
        load_out = (next == ST_DONE) && (accept || step);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            counter     <= '0;
            cand        <= '0;
            cand_idx    <= '0;
            bus.index   <= '0;
            bus.max_val <= '0;
        end else begin
            state    <= next;
            cand     <= cand_nxt;
            cand_idx <= idx_nxt;
            if (accept) begin
                counter <= CNT_W'(1);
            end else if (step) begin
                counter <= counter + CNT_W'(1);
            end
            if (load_out) begin
                bus.index   <= idx_nxt;
                bus.max_val <= cand_nxt;
            end
        end
    end

endmodule
